pcint0_ctrl: RTL and testbench
==============================

PCINT0_CTRL -- requirements
Module: pcint0_ctrl

Interface
REQ-001 Parameter PCIFR_ADDR, 6'h1B, I/O-space address of PCIFR.
REQ-002 Parameter PCICR_ADDR, 8'h68, data-space address of PCICR.
REQ-003 Parameter PCMSK_ADDR, 8'h6B, data-space address of PCMSK0.
REQ-004 Parameter SYNC_STAGES, 2, pin synchronizer depth; legal values 2..3.
REQ-005 Port cp2  in  1  system clock; all state on its rising edge.
REQ-006 Port ireset  in  1  reset; one clock, asynchronous, active-high.
REQ-007 Port IO_Addr  in  6  I/O bus address; iore/iowe  in  1 each  I/O read/write strobes.
REQ-008 Port ramadr  in  8  data-space address; ramre/ramwe  in  1 each  data-space read/write strobes.
REQ-009 Port dbus_in  in  8  write data, shared by both buses.
REQ-010 Port dbus_out  out  8  read data; out_en  out  1  I/O read hit; ram_out_en  out  1  data-space read hit.
REQ-011 Port DIB  in  8  raw PORTB pin levels from the Port B block.
REQ-012 Port PCINT  out  8  PCMSK0 contents; PCIE0  out  1  PCICR bit 0; both feed the Port B digital-input-enable override.
REQ-013 Port irq  out  1  interrupt request; irq_ack  in  1  one-cycle vector-taken pulse from the interrupt controller.

Function
REQ-014 DIB shall pass through a SYNC_STAGES flop chain; pin_prev shall register the last stage; change[i] = sync[i] ^ pin_prev[i].
REQ-015 PCIF0 shall set when |(change & PCMSK0) is high; PCIE0 does not gate flag setting.
REQ-016 Latency: a pin level stable from edge N shall show PCIF0 = 1 after edge N+SYNC_STAGES+1 (N+3 for default).
REQ-017 Pulses shorter than one cp2 period may be missed; no flag for those is required.
REQ-018 Changes on unmasked pins shall never set PCIF0; setting a mask bit on a static pin shall not set PCIF0.
REQ-019 PCIF0 shall clear on an iowe write to PCIFR_ADDR with dbus_in[0] = 1, or on irq_ack; writing 0 leaves it unchanged.
REQ-020 Simultaneous set and clear in the same cycle: set wins, PCIF0 stays 1.
REQ-021 irq = PCIF0 & PCIE0, registered-free combinational from the flag and enable registers.
REQ-022 PCICR write: only bit 0 is stored; PCMSK0 write: all 8 bits are stored; both take effect on the next edge.
REQ-023 Reads: PCIFR -> {7'b0, PCIF0}; PCICR -> {7'b0, PCIE0}; PCMSK0 -> mask; dbus_out = 8'h00 when no hit.
REQ-024 out_en = iore & (IO_Addr == PCIFR_ADDR); ram_out_en = ramre & (ramadr in {PCICR_ADDR, PCMSK_ADDR}); both combinational.
REQ-025 Warm-up FSM states WARM and RUN; WARM holds for SYNC_STAGES+1 cycles after reset via a 2-bit counter, with flag setting suppressed; then RUN, terminal until reset.

Reset
REQ-026 While ireset = 1: sync chain, pin_prev, PCMSK0, PCIE0, PCIF0 = 0; counter = 0; FSM = WARM; irq = 0.
REQ-027 Reset asserted mid-operation shall discard any pending change; no flag shall arise from pre-reset pin history.

Structure
REQ-028 Address constants (PCIFR, PCICR, PCMSK0) shall live in the shared GPIO package, not as literals.
REQ-029 The synchronizer plus pin_prev shall be a sub-module, pcint_sync, parameterized by width and SYNC_STAGES.

Verification
REQ-030 Reset, DIB = 8'hFF held: after 10 cycles PCIF0 = 0, irq = 0 (warm-up suppression).
REQ-031 PCMSK0 = 8'h04, PCIE0 = 1, DIB[2] 0->1 at edge N: PCIF0 = 1 and irq = 1 after edge N+3; DIB[3] toggle with mask 8'h04: no flag.
REQ-032 PCIF0 = 1, write 8'h01 to IO 6'h1B: flag 0 next cycle; write 8'h00: flag stays 1.
REQ-033 Masked pin change arriving in same cycle as irq_ack: PCIF0 remains 1.
REQ-034 PCIE0 = 0, masked change: PCIF0 = 1, irq = 0; then write PCICR 8'h01: irq = 1 next cycle.
REQ-035 ireset pulsed 1 cycle after a masked change at edge N: PCIF0 = 0 through N+10, registers read back 8'h00.

Source files
------------

// File: rtl/pcint0_ctrl_pkg.sv
// Shared GPIO definitions: register addresses and the pin-change warm-up state type.
package pcint0_ctrl_pkg;

    localparam logic [5:0] GPIO_PCIFR_ADDR  = 6'h1B;
    localparam logic [7:0] GPIO_PCICR_ADDR  = 8'h68;
    localparam logic [7:0] GPIO_PCMSK0_ADDR = 8'h6B;

    typedef enum logic {
        ST_WARM = 1'b0,
        ST_RUN  = 1'b1
    } warm_state_t;

    function automatic logic [7:0] bit0_reg(input logic b);
        return {7'b0, b};
    endfunction

endpackage

// File: rtl/pcint_sync.sv
// Pin synchronizer chain plus previous-level register; reports per-pin level changes.
module pcint_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] change
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] pin_prev_q;
    logic [WIDTH-1:0] pin_prev_d;

    always_comb begin
        sync_d[0] = din;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        pin_prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            pin_prev_q <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            pin_prev_q <= pin_prev_d;
        end
    end

    assign change = sync_q[SYNC_STAGES-1] ^ pin_prev_q;

endmodule

// File: rtl/pcint0_ctrl.sv
// Port B pin-change interrupt 0: mask, enable and flag registers with bus access and irq.
module pcint0_ctrl
    import pcint0_ctrl_pkg::*;
#(
    parameter logic [5:0] PCIFR_ADDR  = GPIO_PCIFR_ADDR,
    parameter logic [7:0] PCICR_ADDR  = GPIO_PCICR_ADDR,
    parameter logic [7:0] PCMSK_ADDR  = GPIO_PCMSK0_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       cp2,
    input  logic       ireset,
    input  logic [5:0] IO_Addr,
    input  logic       iore,
    input  logic       iowe,
    input  logic [7:0] ramadr,
    input  logic       ramre,
    input  logic       ramwe,
    input  logic [7:0] dbus_in,
    output logic [7:0] dbus_out,
    output logic       out_en,
    output logic       ram_out_en,
    input  logic [7:0] DIB,
    output logic [7:0] PCINT,
    output logic       PCIE0,
    output logic       irq,
    input  logic       irq_ack
);

    localparam logic [1:0] WARM_LAST = 2'(SYNC_STAGES);

    logic [7:0]  change;
    logic [7:0]  mask_q, mask_d;
    logic        pcie_q, pcie_d;
    logic        pcif_q, pcif_d;
    logic [1:0]  cnt_q, cnt_d;
    warm_state_t state_q, state_d;

    logic pcifr_wr, pcicr_wr, pcmsk_wr;
    logic pcicr_rd, pcmsk_rd;
    logic pcif_set, pcif_clr;

    pcint_sync #(
        .WIDTH      (8),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (cp2),
        .rst   (ireset),
        .din   (DIB),
        .change(change)
    );

    assign pcifr_wr = iowe  & (IO_Addr == PCIFR_ADDR);
    assign pcicr_wr = ramwe & (ramadr == PCICR_ADDR);
    assign pcmsk_wr = ramwe & (ramadr == PCMSK_ADDR);
    assign pcicr_rd = ramre & (ramadr == PCICR_ADDR);
    assign pcmsk_rd = ramre & (ramadr == PCMSK_ADDR);

    // Warm-up lets pin_prev catch up with the pins before any change can be flagged.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WARM: begin
                if (cnt_q == WARM_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        mask_d   = pcmsk_wr ? dbus_in : mask_q;
        pcie_d   = pcicr_wr ? dbus_in[0] : pcie_q;
        pcif_set = (state_q == ST_RUN) & (|(change & mask_q));
        pcif_clr = (pcifr_wr & dbus_in[0]) | irq_ack;
        // A new change beats a simultaneous clear so no edge is lost.
        pcif_d   = pcif_set | (pcif_q & ~pcif_clr);
    end

    always_ff @(posedge cp2 or posedge ireset) begin
        if (ireset) begin
            mask_q  <= 8'h00;
            pcie_q  <= 1'b0;
            pcif_q  <= 1'b0;
            cnt_q   <= 2'd0;
            state_q <= ST_WARM;
        end else begin
            mask_q  <= mask_d;
            pcie_q  <= pcie_d;
            pcif_q  <= pcif_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign out_en     = iore & (IO_Addr == PCIFR_ADDR);
    assign ram_out_en = pcicr_rd | pcmsk_rd;

    always_comb begin
        dbus_out = 8'h00;
        if (out_en) begin
            dbus_out = bit0_reg(pcif_q);
        end else if (pcicr_rd) begin
            dbus_out = bit0_reg(pcie_q);
        end else if (pcmsk_rd) begin
            dbus_out = mask_q;
        end
    end

    assign PCINT = mask_q;
    assign PCIE0 = pcie_q;
    assign irq   = pcif_q & pcie_q;

endmodule

// File: tb/tb_pcint0_ctrl.sv
// Directed bench for pcint0_ctrl: warm-up, latency, masking, clear/ack races and reset.
module tb_pcint0_ctrl;

    logic       cp2 = 1'b0;
    logic       ireset = 1'b1;
    logic [5:0] IO_Addr = 6'h00;
    logic       iore = 1'b0;
    logic       iowe = 1'b0;
    logic [7:0] ramadr = 8'h00;
    logic       ramre = 1'b0;
    logic       ramwe = 1'b0;
    logic [7:0] dbus_in = 8'h00;
    logic [7:0] dbus_out;
    logic       out_en;
    logic       ram_out_en;
    logic [7:0] DIB = 8'hFF;
    logic [7:0] PCINT;
    logic       PCIE0;
    logic       irq;
    logic       irq_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    pcint0_ctrl dut (
        .cp2       (cp2),
        .ireset    (ireset),
        .IO_Addr   (IO_Addr),
        .iore      (iore),
        .iowe      (iowe),
        .ramadr    (ramadr),
        .ramre     (ramre),
        .ramwe     (ramwe),
        .dbus_in   (dbus_in),
        .dbus_out  (dbus_out),
        .out_en    (out_en),
        .ram_out_en(ram_out_en),
        .DIB       (DIB),
        .PCINT     (PCINT),
        .PCIE0     (PCIE0),
        .irq       (irq),
        .irq_ack   (irq_ack)
    );

    always #5 cp2 = ~cp2;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge cp2);
    endtask

    task automatic io_write(input logic [5:0] a, input logic [7:0] d);
        IO_Addr = a; dbus_in = d; iowe = 1'b1;
        @(negedge cp2);
        iowe = 1'b0;
    endtask

    task automatic ram_write(input logic [7:0] a, input logic [7:0] d);
        ramadr = a; dbus_in = d; ramwe = 1'b1;
        @(negedge cp2);
        ramwe = 1'b0;
    endtask

    task automatic chk_flag(input string tag, input logic exp);
        IO_Addr = 6'h1B; iore = 1'b1;
        #1;
        check(tag, dbus_out, {7'b0, exp});
        check("out_en", {7'b0, out_en}, 8'h01);
        iore = 1'b0;
    endtask

    task automatic chk_ram(input string tag, input logic [7:0] a, input logic [7:0] exp);
        ramadr = a; ramre = 1'b1;
        #1;
        check(tag, dbus_out, exp);
        check("ram_out_en", {7'b0, ram_out_en}, 8'h01);
        ramre = 1'b0;
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, {7'b0, irq}, {7'b0, exp});
    endtask

    initial begin
        // Reset state
        tick(2);
        check("rst_irq", {7'b0, irq}, 8'h00);
        check("rst_pcint", PCINT, 8'h00);
        check("rst_pcie0", {7'b0, PCIE0}, 8'h00);
        check("nohit_dbus", dbus_out, 8'h00);
        chk_flag("rst_pcif0", 1'b0);

        // Release with pins high and mask written at once: warm-up must hide the 0->1 transient
        ireset = 1'b0;
        ram_write(8'h6B, 8'hFF);
        tick(10);
        chk_flag("warm_pcif0", 1'b0);
        chk_irq("warm_irq", 1'b0);

        ram_write(8'h68, 8'h01);
        ram_write(8'h6B, 8'h04);
        check("pcie0_port", {7'b0, PCIE0}, 8'h01);
        check("pcint_port", PCINT, 8'h04);
        chk_ram("rd_pcicr", 8'h68, 8'h01);
        chk_ram("rd_pcmsk", 8'h6B, 8'h04);
        ramadr = 8'h6A; ramre = 1'b1; #1;
        check("nohit_ram", dbus_out, 8'h00);
        check("nohit_ramen", {7'b0, ram_out_en}, 8'h00);
        ramre = 1'b0;

        // Masked 1->0 change sets the flag; writing 0 keeps it, writing 1 clears it
        DIB = 8'hFB;
        tick(4);
        chk_flag("fall_pcif0", 1'b1);
        chk_irq("fall_irq", 1'b1);
        io_write(6'h1B, 8'h00);
        chk_flag("wr0_keep", 1'b1);
        io_write(6'h1B, 8'h01);
        chk_flag("wr1_clear", 1'b0);
        chk_irq("wr1_irq", 1'b0);

        // Latency: change after edge N, flag visible only after edge N+3
        DIB = 8'hFF;
        tick(2);
        chk_flag("lat_n2", 1'b0);
        chk_irq("lat_n2_irq", 1'b0);
        tick(1);
        chk_flag("lat_n3", 1'b1);
        chk_irq("lat_n3_irq", 1'b1);

        // Unmasked pin toggles never flag
        io_write(6'h1B, 8'h01);
        DIB = 8'hF7;
        tick(5);
        chk_flag("unmask_fall", 1'b0);
        DIB = 8'hFF;
        tick(5);
        chk_flag("unmask_rise", 1'b0);

        // Unmasking a static pin does not flag
        ram_write(8'h6B, 8'h0C);
        tick(4);
        chk_flag("static_mask", 1'b0);
        ram_write(8'h6B, 8'h04);

        // Set and irq_ack in the same cycle: set wins
        DIB = 8'hFB;
        tick(4);
        chk_flag("pre_race", 1'b1);
        DIB = 8'hFF;
        tick(2);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        chk_flag("race_set_wins", 1'b1);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        chk_flag("ack_clear", 1'b0);

        // Flag independent of enable; enabling later raises irq
        ram_write(8'h68, 8'h00);
        DIB = 8'hFB;
        tick(4);
        chk_flag("dis_pcif0", 1'b1);
        chk_irq("dis_irq", 1'b0);
        ram_write(8'h68, 8'h01);
        chk_irq("en_irq", 1'b1);
        ram_write(8'h68, 8'hFE);
        chk_ram("pcicr_bit0", 8'h68, 8'h00);
        chk_irq("fe_irq", 1'b0);

        // Reset one cycle after a masked change: nothing must survive
        io_write(6'h1B, 8'h01);
        ram_write(8'h68, 8'h01);
        DIB = 8'hFF;
        tick(1);
        ireset = 1'b1;
        tick(1);
        ireset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk_flag("post_rst_flag", 1'b0);
            chk_irq("post_rst_irq", 1'b0);
            tick(1);
        end
        chk_ram("post_rst_pcicr", 8'h68, 8'h00);
        chk_ram("post_rst_pcmsk", 8'h6B, 8'h00);
        chk_flag("post_rst_pcifr", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
